cn_key_expand: RTL and testbench

Iterative AES-256 key-schedule engine for the CryptoNight scratchpad stages. It takes a 256-bit key and a key-set select, computes the ten 128-bit round keys CryptoNight uses, and writes one per cycle into the round-key RAM. That RAM is indexed as `{round[3:0], set}`, so 20 entries hold two interleaved schedules, even/odd. The block sits directly upstream of the round-key RAM: its `we`/`waddr`/`din` outputs drive the RAM write port.

---
 rtl/cn_aes_pkg.sv | 45 ++++
 rtl/aes_sbox.sv | 29 ++
 rtl/cn_key_expand.sv | 113 +++++++++++
 tb/tb_cn_key_expand.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cn_aes_pkg.sv
// Shared AES key-schedule definitions: sizing constants, FSM encoding, Rcon and word helpers.
// Pure declarations, no logic of its own.
package cn_aes_pkg;

    localparam int NUM_RK   = 10;
    localparam int NUM_SETS = 2;
    localparam int RK_IDX_W = 4;
    localparam int ADDR_W   = RK_IDX_W + $clog2(NUM_SETS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ks_state_e;

    // Indexed by n/2; entry 0 is never used by an even round key.
    localparam logic [7:0] RCON [0:7] = '{8'h00, 8'h01, 8'h02, 8'h04,
                                          8'h08, 8'h10, 8'h20, 8'h40};

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[7:0], w[31:8]};
    endfunction

    function automatic logic [7:0] rcon_byte(input logic [3:0] n);
        return RCON[n[3:1]];
    endfunction

    // Even round keys substitute the rotated word, odd ones the plain word.
    function automatic logic [31:0] sub_word_in(input logic [31:0] w, input logic odd);
        return odd ? w : rot_word(w);
    endfunction

    function automatic logic [127:0] chain_words(input logic [127:0] p2, input logic [31:0] t);
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        w0 = p2[31:0]   ^ t;
        w1 = p2[63:32]  ^ w0;
        w2 = p2[95:64]  ^ w1;
        w3 = p2[127:96] ^ w2;
        return {w3, w2, w1, w0};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Zero latency; no flow control.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign dout = SBOX[din];

endmodule

// File: rtl/cn_key_expand.sv
// Iterative AES-256 key schedule: one 128-bit round key written to the round-key RAM per cycle.
// Latency: first write the cycle after start, ten writes, then a one-cycle done pulse.
// No backpressure: start is only accepted in IDLE and is dropped (not queued) otherwise.
module cn_key_expand #(
    parameter int NUM_RK = cn_aes_pkg::NUM_RK
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         set,
    input  logic [255:0] key,
    output logic         busy,
    output logic         done,
    output logic         we,
    output logic [4:0]   waddr,
    output logic [127:0] din
);

    import cn_aes_pkg::*;

    ks_state_e    state_q, state_d;
    logic [3:0]   rk_q, rk_d;
    logic         set_q, set_d;
    logic [127:0] cur_q, cur_d;
    logic [127:0] prv_q, prv_d;

    logic [3:0]   n_next;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  t_word;
    logic [127:0] rk_next;
    logic         last_rk;

    // cur_q is the key being written now (RK[rk]) and prv_q is RK[rk-1]; the
    // upper key half parks in prv_q during the RK0 cycle so no extra key register is needed.
    assign n_next  = rk_q + 4'd1;
    assign sub_in  = sub_word_in(cur_q[127:96], n_next[0]);
    assign t_word  = sub_out ^ (n_next[0] ? 32'h0 : {24'h0, rcon_byte(n_next)});
    assign rk_next = (rk_q == 4'd0) ? prv_q : chain_words(prv_q, t_word);
    assign last_rk = (rk_q == 4'(NUM_RK - 1));

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (sub_in[8*i +: 8]),
            .dout (sub_out[8*i +: 8])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            rk_q    <= 4'd0;
            set_q   <= 1'b0;
            cur_q   <= '0;
            prv_q   <= '0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            set_q   <= set_d;
            cur_q   <= cur_d;
            prv_q   <= prv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last_rk) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rk_d  = rk_q;
        set_d = set_q;
        cur_d = cur_q;
        prv_d = prv_q;
        if (state_q == ST_IDLE && start) begin
            rk_d  = 4'd0;
            set_d = set;
            cur_d = key[127:0];
            prv_d = key[255:128];
        end else if (state_q == ST_RUN && !last_rk) begin
            rk_d  = n_next;
            cur_d = rk_next;
            prv_d = cur_q;
        end
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        we    = 1'b0;
        waddr = 5'd0;
        din   = '0;
        case (state_q)
            ST_RUN: begin
                busy  = 1'b1;
                we    = 1'b1;
                waddr = {rk_q, set_q};
                din   = cur_q;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cn_key_expand.sv
// Bench for cn_key_expand: scoreboard of expected RAM writes from an independent AES-256 model.
module tb_cn_key_expand;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         set;
    logic [255:0] key;
    logic         busy;
    logic         done;
    logic         we;
    logic [4:0]   waddr;
    logic [127:0] din;

    cn_key_expand dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .set     (set),
        .key     (key),
        .busy    (busy),
        .done    (done),
        .we      (we),
        .waddr   (waddr),
        .din     (din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]   addr;
        logic [127:0] dat;
    } wr_t;

    typedef struct {
        logic [255:0] key;
        logic         s;
        int           idx;
        logic [127:0] exp;
    } vec_t;

    wr_t          exp_q [$];
    logic [127:0] ram [0:31];
    logic [7:0]   sb [0:255];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           we_cnt   = 0;
    int           done_cnt = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box derived from GF(2^8) inversion plus the affine map.
    task automatic build_sbox();
        logic [7:0] r, x;
        for (int v = 0; v < 256; v++) begin
            r = 8'h01;
            for (int i = 0; i < 254; i++) r = gmul(r, 8'(v));
            x = r;
            sb[v] = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] model_rk(input logic [255:0] k, input int n);
        logic [31:0] w [0:39];
        logic [31:0] t;
        for (int i = 0; i < 8; i++) w[i] = k[32*i +: 32];
        for (int i = 8; i < 40; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = {t[7:0], t[31:8]};
                t = subw(t) ^ (32'h1 << (i/8 - 1));
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        return {w[4*n+3], w[4*n+2], w[4*n+1], w[4*n]};
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
        return k;
    endfunction

    task automatic push_sched(input logic [255:0] k, input logic s);
        wr_t e;
        for (int n = 0; n < 10; n++) begin
            e.addr = {4'(n), s};
            e.dat  = model_rk(k, n);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (done) done_cnt++;
        if (we) begin
            we_cnt++;
            ram[waddr] = din;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr %0d data %h, required no write", waddr, din);
            end else begin
                e = exp_q.pop_front();
                chk("write", {waddr, din}, {e.addr, e.dat});
            end
        end
    end

    // Start in cycle T; returns in cycle T+12, the earliest restart slot.
    task automatic run_one(input logic [255:0] k, input logic s);
        int wc0, dc0;
        bit seen;
        wc0 = we_cnt; dc0 = done_cnt;
        push_sched(k, s);
        key = k; set = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (done) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("done_seen", seen, 1);
        @(posedge clk); #1;
        chk("we_count", we_cnt - wc0, 10);
        chk("done_count", done_cnt - dc0, 1);
    endtask

    initial begin
        vec_t vt [7];
        logic [255:0] kseq, ka, kb;
        int wc0, dc0;

        for (int b = 0; b < 32; b++) kseq[8*b +: 8] = 8'(b);
        vt[0] = '{256'h0, 1'b0, 0, 128'h0};
        vt[1] = '{256'h0, 1'b0, 1, 128'h0};
        vt[2] = '{256'h0, 1'b0, 2, 128'h63636362_63636362_63636362_63636362};
        vt[3] = '{256'h0, 1'b0, 3, 128'hfbfbfbaa_fbfbfbaa_fbfbfbaa_fbfbfbaa};
        vt[4] = '{kseq,   1'b1, 0, 128'h0f0e0d0c_0b0a0908_07060504_03020100};
        vt[5] = '{kseq,   1'b1, 1, 128'h1f1e1d1c_1b1a1918_17161514_13121110};
        vt[6] = '{kseq,   1'b1, 2, 128'h9cc072a5_93ce7fa9_98c476a1_9fc273a5};

        reset_n = 1'b0; start = 1'b0; set = 1'b0; key = '0;
        build_sbox();
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_din", din, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_one(vt[i].key, vt[i].s);
            chk($sformatf("vec%0d", i), ram[{4'(vt[i].idx), vt[i].s}], vt[i].exp);
        end

        // Cycle-accurate timing with starts dropped during RUN and DONE.
        ka = rand_key();
        wc0 = we_cnt; dc0 = done_cnt;
        push_sched(ka, 1'b0);
        key = ka; set = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 13; c++) begin
            chk($sformatf("t%0d_busy", c), busy, (c <= 11));
            chk($sformatf("t%0d_we", c), we, (c <= 10));
            chk($sformatf("t%0d_done", c), done, (c == 11));
            if (c == 3 || c == 11) begin start = 1'b1; set = 1'b1; key = ~ka; end
            else start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("ign_we_count", we_cnt - wc0, 10);
        chk("ign_done_count", done_cnt - dc0, 1);
        chk("ign_queue", exp_q.size(), 0);

        // Reset in cycle T+5 aborts the run.
        ka = rand_key();
        wc0 = we_cnt; dc0 = done_cnt;
        push_sched(ka, 1'b0);
        key = ka; set = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        chk("abort_we", we, 0);
        chk("abort_busy", busy, 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        chk("abort_writes", we_cnt - wc0, 4);
        chk("abort_no_done", done_cnt - dc0, 0);
        run_one(rand_key(), 1'b1);

        // Back-to-back interleaved schedules.
        ka = rand_key();
        kb = rand_key();
        run_one(ka, 1'b0);
        run_one(kb, 1'b1);
        for (int n = 0; n < 10; n++) begin
            chk($sformatf("ram_even%0d", n), ram[{4'(n), 1'b0}], model_rk(ka, n));
            chk($sformatf("ram_odd%0d", n), ram[{4'(n), 1'b1}], model_rk(kb, n));
        end

        for (int r = 0; r < 1000; r++) run_one(rand_key(), 1'($urandom_range(0, 1)));

        chk("final_queue", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
